// File: rtl/device_regs_bank.sv
// device_regs_bank
//   Parametrised device register bank between the host register bus and
//   device logic.
//
//   Register map:
//     0 .. NUM_REGS-1 : general R/W registers, exported on reg_out
//     NUM_REGS        : STATUS, sticky bits set by hw_event, cleared by writing 1
//     NUM_REGS+1      : INT_MASK
//     NUM_REGS+2      : LOCK, present only when DEVICE_REGS_WLOCK_EN is defined
//     anything higher : unmapped
//
//   Optional feature macro: DEVICE_REGS_WLOCK_EN (write lock register).
//
//   Bus strobe semantics:
//     - write_en and read_en are single-cycle strobes. Each one is sampled at a
//       posedge and is acted on at that same edge; there is no backpressure.
//     - A read sampled at edge N drives read_data and read_valid at edge N.
//       The value returned is the state before any write in that same cycle.
//     - read_valid is high for exactly one cycle per accepted read. read_data
//       holds its value while read_en is low.
//     - addr_err is a one-cycle pulse for an access to an unmapped address, or
//       for a write that is blocked by the lock. If both strobes are high in
//       the same cycle, only one pulse is produced.
module device_regs_bank #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          address,
  input  logic                       write_en,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       read_en,
  output logic [DATA_W-1:0]          read_data,
  output logic                       read_valid,
  output logic                       addr_err,
  input  logic [DATA_W-1:0]          hw_event,
  output logic                       irq,
  output logic [NUM_REGS*DATA_W-1:0] reg_out
);

  // Addresses are compared at the full address width, so indices never alias.
  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(NUM_REGS);
  localparam logic [ADDR_W-1:0] MASK_ADDR   = ADDR_W'(NUM_REGS + 1);
`ifdef DEVICE_REGS_WLOCK_EN
  localparam logic [ADDR_W-1:0] LOCK_ADDR   = ADDR_W'(NUM_REGS + 2);
`endif

  logic [DATA_W-1:0] gen_q [NUM_REGS];
  logic [DATA_W-1:0] status_q;
  logic [DATA_W-1:0] int_mask_q;
  logic              locked;

  logic [NUM_REGS-1:0] sel_gen;
  logic                sel_status;
  logic                sel_mask;
  logic                sel_lock;
  logic                mapped;
  logic                wr_blocked;
  logic [DATA_W-1:0]   rd_value;
  logic [DATA_W-1:0]   w1c_bits;
  logic                addr_err_d;

`ifdef DEVICE_REGS_WLOCK_EN
  logic lock_q;

  // Lock bit: writing 1 sets it, and only a reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q <= 1'b0;
    end else if (write_en && sel_lock && data_in[0]) begin
      lock_q <= 1'b1;
    end
  end

  assign locked = lock_q;
`else
  assign locked = 1'b0;
`endif

  // Address decode, read mux and error detection for the current access.
  always_comb begin
    sel_gen    = '0;
    sel_status = 1'b0;
    sel_mask   = 1'b0;
    sel_lock   = 1'b0;
    rd_value   = '0;
    w1c_bits   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (address == ADDR_W'(i)) begin
        sel_gen[i] = 1'b1;
        rd_value   = gen_q[i];
      end
    end
    if (address == STATUS_ADDR) begin
      sel_status = 1'b1;
      rd_value   = status_q;
    end
    if (address == MASK_ADDR) begin
      sel_mask = 1'b1;
      rd_value = int_mask_q;
    end
`ifdef DEVICE_REGS_WLOCK_EN
    if (address == LOCK_ADDR) begin
      sel_lock = 1'b1;
      rd_value = DATA_W'(lock_q);
    end
`endif
    mapped = (|sel_gen) | sel_status | sel_mask | sel_lock;
    // The lock protects the general registers and INT_MASK only. STATUS
    // clears are still allowed while locked.
    wr_blocked = write_en & locked & ((|sel_gen) | sel_mask);
    addr_err_d = ((write_en | read_en) & ~mapped) | wr_blocked;
    if (write_en && sel_status) begin
      w1c_bits = data_in;
    end
  end

  // General registers load data_in on an unblocked write to their address.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reset) begin
        gen_q[i] <= '0;
      end else if (write_en && sel_gen[i] && !locked) begin
        gen_q[i] <= data_in;
      end
    end
  end

  // STATUS: an event sets a bit and a host write of 1 clears it. If both
  // happen on the same bit in the same cycle, the event wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      status_q <= '0;
    end else begin
      status_q <= (status_q & ~w1c_bits) | hw_event;
    end
  end

  // INT_MASK is a plain register that is subject to the lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      int_mask_q <= '0;
    end else if (write_en && sel_mask && !locked) begin
      int_mask_q <= data_in;
    end
  end

  // Registered read port. An unmapped read returns 0 but still completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data  <= '0;
      read_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      read_valid <= read_en;
      addr_err   <= addr_err_d;
      if (read_en) begin
        read_data <= mapped ? rd_value : '0;
      end
    end
  end

  // irq follows the committed STATUS and INT_MASK values one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |(status_q & int_mask_q);
    end
  end

  // Flatten the general registers onto reg_out.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_W +: DATA_W] = gen_q[g];
  end

endmodule

// File: tb/tb_device_regs_bank.sv
// tb_device_regs_bank
//   Directed steps followed by random traffic. Expected values come from a
//   behavioural register-map model held in arrays inside the bench.
//   Define DEVICE_REGS_WLOCK_EN to exercise the lock register as well.
module tb_device_regs_bank;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int AW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [AW-1:0]     address;
  logic              write_en;
  logic [DW-1:0]     data_in;
  logic              read_en;
  logic [DW-1:0]     read_data;
  logic              read_valid;
  logic              addr_err;
  logic [DW-1:0]     hw_event;
  logic              irq;
  logic [NR*DW-1:0]  reg_out;

  device_regs_bank #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .address(address), .write_en(write_en),
    .data_in(data_in), .read_en(read_en), .read_data(read_data),
    .read_valid(read_valid), .addr_err(addr_err), .hw_event(hw_event),
    .irq(irq), .reg_out(reg_out)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] m_gen [NR];
  logic [DW-1:0] m_status;
  logic [DW-1:0] m_mask;
  bit            m_lock;
  logic [DW-1:0] m_rd;
  logic [DW-1:0] exp_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit lock_present();
`ifdef DEVICE_REGS_WLOCK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- driver: one bus cycle, then check ----------------
  task automatic cycle(input bit rst, input bit wr, input bit rd, input int addr,
                       input logic [DW-1:0] din, input logic [DW-1:0] ev);
    bit is_gen, is_stat, is_mask, is_lock, mapped, blocked;
    logic [DW-1:0] val;
    bit exp_rv, exp_err, exp_irq;
    logic [NR*DW-1:0] exp_out;

    reset = rst; write_en = wr; read_en = rd; address = AW'(addr);
    data_in = din; hw_event = ev;

    is_gen  = (addr < NR);
    is_stat = (addr == NR);
    is_mask = (addr == NR + 1);
    is_lock = lock_present() && (addr == NR + 2);
    mapped  = is_gen || is_stat || is_mask || is_lock;
    blocked = wr && m_lock && (is_gen || is_mask);

    // Outputs expected after this edge, computed from the state before it.
    val = '0;
    if (is_gen)  val = m_gen[addr];
    if (is_stat) val = m_status;
    if (is_mask) val = m_mask;
    if (is_lock) val = DW'(m_lock);
    exp_irq = rst ? 1'b0 : |(m_status & m_mask);
    exp_rv  = !rst && rd;
    exp_err = !rst && (((wr || rd) && !mapped) || blocked);
    if (rst) m_rd = '0;
    else if (rd) begin
      m_rd = val;
      exp_q.push_back(val);
    end

    // State update.
    if (rst) begin
      for (int i = 0; i < NR; i++) m_gen[i] = '0;
      m_status = '0; m_mask = '0; m_lock = 1'b0;
      exp_q.delete();
    end else begin
      if (wr && is_gen && !m_lock)  m_gen[addr] = din;
      if (wr && is_mask && !m_lock) m_mask = din;
      m_status = (m_status & ~((wr && is_stat) ? din : '0)) | ev;
      if (wr && is_lock && din[0]) m_lock = 1'b1;
    end
    for (int i = 0; i < NR; i++) exp_out[i*DW +: DW] = m_gen[i];

    @(posedge clk);
    #1;
    check("read_valid", 64'(read_valid), 64'(exp_rv));
    check("addr_err",   64'(addr_err),   64'(exp_err));
    check("irq",        64'(irq),        64'(exp_irq));
    check("read_data",  64'(read_data),  64'(m_rd));
    check("reg_out",    64'(reg_out),    64'(exp_out));
    if (exp_rv && exp_q.size() > 0) check("read_q", 64'(read_data), 64'(exp_q.pop_front()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, '0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < NR; i++) m_gen[i] = 'x;
    m_status = 'x; m_mask = 'x; m_lock = 1'b0; m_rd = 'x;

    // Reset held for two cycles: every output must be zero.
    cycle(1, 0, 0, 0, '0, '0);
    cycle(1, 0, 0, 0, '0, '0);
    check("reset_read_data", 64'(read_data), 64'h0);
    check("reset_reg_out", 64'(reg_out), 64'h0);

    // Write then read a general register.
    cycle(0, 1, 0, 1, 8'hA5, '0);
    cycle(0, 0, 1, 1, '0, '0);
    check("reg1_slice", 64'(reg_out[15:8]), 64'hA5);
    idle(1);
    check("read_hold", 64'(read_data), 64'hA5);

    // A write and read of the same address in one cycle returns the old value.
    cycle(0, 1, 1, 2, 8'h3C, '0);
    check("rd_old_value", 64'(read_data), 64'h00);
    cycle(0, 0, 1, 2, '0, '0);
    check("rd_new_value", 64'(read_data), 64'h3C);

    // Interrupt path, including a W1C that collides with a new event.
    cycle(0, 1, 0, NR + 1, 8'h04, '0);
    cycle(0, 0, 0, 0, '0, 8'h04);
    idle(1);
    check("irq_set", 64'(irq), 64'h1);
    cycle(0, 1, 0, NR, 8'h04, 8'h04);
    cycle(0, 0, 1, NR, '0, '0);
    check("status_set_wins", 64'(read_data), 64'h04);
    cycle(0, 1, 0, NR, 8'h04, '0);
    idle(2);
    check("irq_clear", 64'(irq), 64'h0);

    // Unmapped address: both strobes together give a single error pulse.
    cycle(0, 1, 1, 15, 8'hEE, '0);
    check("unmapped_rd", 64'(read_data), 64'h0);
    check("unmapped_err", 64'(addr_err), 64'h1);
    idle(1);
    check("err_pulse_end", 64'(addr_err), 64'h0);

`ifdef DEVICE_REGS_WLOCK_EN
    // Lock: general writes blocked, the lock is sticky, and reset unlocks it.
    cycle(0, 1, 0, 0, 8'h11, '0);
    cycle(0, 1, 0, NR + 2, 8'h01, '0);
    cycle(0, 1, 0, 0, 8'hFF, '0);
    check("lock_err", 64'(addr_err), 64'h1);
    cycle(0, 1, 0, NR + 2, 8'h00, '0);
    cycle(0, 0, 1, NR + 2, '0, '0);
    check("lock_sticky", 64'(read_data), 64'h01);
    cycle(0, 1, 0, NR + 1, 8'hFF, 8'h10);
    cycle(0, 1, 0, NR, 8'hFF, '0);
    cycle(1, 0, 0, 0, '0, '0);
    cycle(0, 1, 0, 0, 8'h77, '0);
    check("unlocked_reg0", 64'(reg_out[7:0]), 64'h77);
`else
    // Without the lock, NR+2 is an unmapped address.
    cycle(0, 1, 1, NR + 2, 8'h01, '0);
    check("no_lock_err", 64'(addr_err), 64'h1);
`endif

    // A reset in the middle of an access discards that access.
    cycle(0, 1, 0, 0, 8'h5A, '0);
    cycle(1, 1, 1, 0, 8'hFF, 8'hFF);
    check("reset_mid_access", 64'(reg_out), 64'h0);

    // Random traffic checked against the model.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 15), DW'($urandom),
            ($urandom_range(0, 3) == 0) ? DW'($urandom) : '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
